// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
// Optional feature macro: EX_MULDIV_DIV_EN (enables DIV/DIVU).
package ex_muldiv_ctrl_pkg;

    localparam int NB       = 32;  // datapath width
    localparam int NB_FCODE = 6;   // funct field width
    localparam int NB_CNT   = 6;   // iteration counter width, must hold NB

    localparam logic [NB_FCODE-1:0] FC_MFHI  = 6'h10;
    localparam logic [NB_FCODE-1:0] FC_MTHI  = 6'h11;
    localparam logic [NB_FCODE-1:0] FC_MFLO  = 6'h12;
    localparam logic [NB_FCODE-1:0] FC_MTLO  = 6'h13;
    localparam logic [NB_FCODE-1:0] FC_MULT  = 6'h18;
    localparam logic [NB_FCODE-1:0] FC_MULTU = 6'h19;
    localparam logic [NB_FCODE-1:0] FC_DIV   = 6'h1A;
    localparam logic [NB_FCODE-1:0] FC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Operand magnitude: absolute value for signed ops, raw bits otherwise.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    function automatic logic [NB-1:0] op_mag(input logic [NB-1:0] v,
                                             input logic          is_signed);
        return (is_signed && v[NB-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage <-> mul/div sequencer signal bundle.
// master = EX stage (drives the instruction), slave = sequencer.
interface ex_muldiv_ctrl_if;
    import ex_muldiv_ctrl_pkg::*;

    logic                i_valid;
    logic                i_flush;
    logic [NB_FCODE-1:0] i_funct_code;
    logic [NB-1:0]       i_data_a;
    logic [NB-1:0]       i_data_b;
    logic                o_stall;
    logic                o_busy;
    logic [NB-1:0]       o_result;
    logic [NB-1:0]       o_hi;
    logic [NB-1:0]       o_lo;
    logic                o_div_by_zero;

    modport master (
        output i_valid, i_flush, i_funct_code, i_data_a, i_data_b,
        input  o_stall, o_busy, o_result, o_hi, o_lo, o_div_by_zero
    );

    modport slave (
        input  i_valid, i_flush, i_funct_code, i_data_a, i_data_b,
        output o_stall, o_busy, o_result, o_hi, o_lo, o_div_by_zero
    );

endinterface

// File: rtl/ex_muldiv_ctrl_muldiv_step.sv
// One iteration of the sequencer datapath on the {hi, lo} accumulator.
//   mode_i = 0 : shift-add multiply. {hi, lo} = {partial product, multiplier};
//                after NB steps it holds the 2NB-bit product.
//   mode_i = 1 : restoring divide. {hi, lo} = {remainder, dividend/quotient};
//                after NB steps hi = remainder and lo = quotient.
// The divide path exists only with EX_MULDIV_DIV_EN defined.
module muldiv_step
    import ex_muldiv_ctrl_pkg::*;
(
    input  logic          mode_i,
    input  logic [NB-1:0] hi_i,
    input  logic [NB-1:0] lo_i,
    input  logic [NB-1:0] opb_i,
    output logic [NB-1:0] hi_o,
    output logic [NB-1:0] lo_o
);

    logic [NB:0]   sum;
`ifdef EX_MULDIV_DIV_EN
    logic [NB:0]   shifted;
    logic [NB+1:0] diff;
`else
    logic          unused_mode;
    assign unused_mode = mode_i;
`endif

    // Single add/shift or subtract/restore step, chosen by mode
    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
        hi_o = sum[NB:1];
        lo_o = {sum[0], lo_i[NB-1:1]};
`ifdef EX_MULDIV_DIV_EN
        shifted = {hi_i, lo_i[NB-1]};
        diff    = {1'b0, shifted} - {2'b00, opb_i};
        if (mode_i) begin
            // Non-negative trial difference always fits NB bits because the
            // running remainder stays below the divisor.
            if (diff[NB+1:NB] == 2'b00) begin
                hi_o = diff[NB-1:0];
                lo_o = {lo_i[NB-2:0], 1'b1};
            end else begin
                hi_o = shifted[NB-1:0];
                lo_o = {lo_i[NB-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage. Owns HI/LO and
// serves MFHI/MFLO/MTHI/MTLO. Stalls the pipeline while iterating.
// Optional feature macro: EX_MULDIV_DIV_EN (divide support; when undefined
// DIV/DIVU are no-ops and the divider is removed).
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset,
    ex_muldiv_ctrl_if.slave bus
);

    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB - 1);

    state_t            state_q, state_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic [NB-1:0]     acc_hi_q, acc_hi_d;
    logic [NB-1:0]     acc_lo_q, acc_lo_d;
    logic [NB-1:0]     opb_q, opb_d;
    logic              neg_q, neg_d;     // product / quotient sign
    logic              rneg_q, rneg_d;   // remainder sign (dividend sign)
    logic              dz_q, dz_d;       // divide by zero seen
    logic              busy_q;
    logic [NB-1:0]     hi_q, hi_d;
    logic [NB-1:0]     lo_q, lo_d;

    logic              is_mul, is_div, issue, start, sgn;
    logic [NB-1:0]     step_hi, step_lo;
    logic [2*NB-1:0]   prod;

    muldiv_step u_step (
        .mode_i (state_q == ST_DIV),
        .hi_i   (acc_hi_q),
        .lo_i   (acc_lo_q),
        .opb_i  (opb_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    // Instruction decode for the current EX slot
    always_comb begin
        is_mul = (bus.i_funct_code == FC_MULT) || (bus.i_funct_code == FC_MULTU);
`ifdef EX_MULDIV_DIV_EN
        is_div = (bus.i_funct_code == FC_DIV) || (bus.i_funct_code == FC_DIVU);
`else
        is_div = 1'b0;
`endif
        issue  = (state_q == ST_IDLE) && bus.i_valid && !bus.i_flush;
        start  = issue && (is_mul || is_div);
        sgn    = ~bus.i_funct_code[0];  // MULT/DIV even, MULTU/DIVU odd
        prod   = {step_hi, step_lo};
    end

    // Next-state, iteration datapath and HI/LO commit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_hi_d = '0;
                    acc_lo_d = op_mag(bus.i_data_a, sgn);
                    opb_d    = op_mag(bus.i_data_b, sgn);
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    neg_d    = sgn & (bus.i_data_a[NB-1] ^ bus.i_data_b[NB-1]);
                    rneg_d   = sgn & bus.i_data_a[NB-1];
                    if (is_mul) begin
                        state_d = ST_MUL;
                    end else if (bus.i_data_b == '0) begin
                        // Divide by zero skips iteration and commits at once
                        state_d = ST_DONE;
                        dz_d    = 1'b1;
                        lo_d    = '1;
                        hi_d    = bus.i_data_a;
                    end else begin
                        state_d = ST_DIV;
                    end
                end else if (issue && bus.i_funct_code == FC_MTHI) begin
                    hi_d = bus.i_data_a;
                end else if (issue && bus.i_funct_code == FC_MTLO) begin
                    lo_d = bus.i_data_a;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + NB_CNT'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        if (state_q == ST_MUL) begin
                            {hi_d, lo_d} = neg_q ? -prod : prod;
                        end else begin
                            lo_d = neg_q  ? -step_lo : step_lo;
                            hi_d = rneg_q ? -step_hi : step_hi;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Datapath, HI/LO and busy registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            busy_q   <= (state_d != ST_IDLE);
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Stall covers the issue cycle combinationally; reset forces it low
    assign bus.o_stall  = ~i_reset & (start | (state_q == ST_MUL) | (state_q == ST_DIV));
    assign bus.o_busy   = busy_q;
    assign bus.o_hi     = hi_q;
    assign bus.o_lo     = lo_q;
    assign bus.o_result = (bus.i_funct_code == FC_MFHI) ? hi_q :
                          (bus.i_funct_code == FC_MFLO) ? lo_q : '0;
`ifdef EX_MULDIV_DIV_EN
    assign bus.o_div_by_zero = (state_q == ST_DONE) & dz_q;
`else
    logic unused_dz;
    assign unused_dz = dz_q;
    assign bus.o_div_by_zero = 1'b0;
`endif

endmodule
